data_bus_master: RTL and testbench
==================================

Name: data_bus_master

Overview:
Memory-stage bus master sitting directly downstream of the byte-lane store/load formatter. It takes the formatted word, byte strobes and address, and runs one request/grant/response transaction on the SoC data bus. It stalls the pipeline until the transaction completes, then returns the raw 32-bit read word to the formatter's load path.

Parameters:
ADDR_WIDTH, 32, width of core and bus addresses
TIMEOUT_CYCLES, 256, cycles in REQ+WAIT before forced abort; used only with BUS_TIMEOUT_EN

Ports:
clk_i  input  1  clock, all logic rising-edge
rst_n_i  input  1  asynchronous active-low reset
mem_read_i  input  1  load request from memory stage
mem_write_i  input  1  store request from memory stage
addr_i  input  ADDR_WIDTH  byte address of access
data_to_mem_i  input  32  lane-replicated store data
byte_select_i  input  4  byte strobes from formatter
data_from_mem_o  output  32  raw word read, to formatter load path
stall_o  output  1  freeze pipeline while access pending
err_o  output  1  bus error for completing access
bus_req_o  output  1  request valid
bus_we_o  output  1  1=write, 0=read
bus_addr_o  output  ADDR_WIDTH  word-aligned address
bus_wdata_o  output  32  write data
bus_be_o  output  4  byte enables (all ones on reads)
bus_gnt_i  input  1  slave accepts request
bus_rvalid_i  input  1  response valid (reads and writes)
bus_rdata_i  input  32  read data, valid with bus_rvalid_i
bus_err_i  input  1  error flag, valid with bus_rvalid_i

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_n_i). On reset: state IDLE; bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0, data_from_mem_o=0, err_o=0. Reset mid-transaction abandons it; bus_req_o drops immediately.
- req = mem_read_i | mem_write_i. stall_o = req & (state != RESP), combinational.
- IDLE: if req, register bus_we_o=mem_write_i (write wins if both high; both high is illegal), bus_addr_o={addr_i[ADDR_WIDTH-1:2],2'b00}, bus_wdata_o=data_to_mem_i, bus_be_o=(write ? byte_select_i : 4'b1111). Then -> REQ.
- REQ: bus_req_o=1, and the bus fields stay stable. On bus_gnt_i -> WAIT, and bus_req_o deasserts the next cycle.
- WAIT: on bus_rvalid_i, capture data_from_mem_o=bus_rdata_i (reads only; writes hold the old value) and err_o=bus_err_i. Then -> RESP.
- RESP: one cycle. stall_o=0, so the pipeline advances. -> IDLE. err_o clears on leaving RESP.
- Minimum latency: IDLE (latch), REQ (gnt), WAIT (rvalid), RESP. stall_o is high for 3 cycles. Slave never asserts rvalid in the same cycle as gnt.
- bus_rvalid_i in IDLE/REQ is ignored.
- Core drops req mid-transaction (flush): the transaction still completes through RESP. Results are discarded by the core, and no new request starts before IDLE.
- data_from_mem_o holds its last read value between loads.
- Back-to-back: new request in the cycle after RESP is latched in IDLE normally.

Optional Feature:
BUS_TIMEOUT_EN: defined -> counter resets on IDLE->REQ and increments in REQ/WAIT. When it reaches TIMEOUT_CYCLES-1 without completion: bus_req_o drops, data_from_mem_o=0, err_o=1, -> RESP. A late rvalid arriving afterwards in IDLE/REQ is ignored. Undefined -> no counter, and the master waits indefinitely.

Decomposition:
- Shared package/include dbm_defs: state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3) and default TIMEOUT_CYCLES constant.
- Optional sub-module bus_timeout_counter (clear, enable, expired), instantiated only under BUS_TIMEOUT_EN.
- FSM and datapath registers stay in the top module.

Test Plan:
- lw, addr=0x1004, gnt in cycle 2, rvalid in cycle 3 with rdata 0xCAFEBABE -> bus_addr_o=0x1004, be=4'b1111, we=0, stall high 3 cycles, data_from_mem_o=0xCAFEBABE in RESP.
- sb, addr=0x2003, byte_select=4'b1000, data 0x5A5A5A5A -> bus_addr_o=0x2000, be=4'b1000, we=1, wdata=0x5A5A5A5A, data_from_mem_o unchanged.
- gnt withheld 5 cycles, then rvalid 2 cycles later -> bus_req_o and bus fields stable for 6 cycles, stall_o=1 until RESP, exactly one req/gnt handshake.
- Read with bus_err_i=1 -> err_o=1 for exactly the RESP cycle, stall_o=0 that cycle.
- rst_n_i low while in WAIT -> bus_req_o=0 and state IDLE immediately; stray rvalid after reset ignored; next load completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt never given -> abort after 16 cycles in REQ, err_o=1, data_from_mem_o=0, stall_o released.

Source files
------------

// File: rtl/dbm_defs_pkg.sv
// Shared definitions for the data bus master: FSM state encodings,
// default abort timeout and the byte-enable selection helper.
package dbm_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } dbm_state_t;

    localparam int DBM_TIMEOUT_DEFAULT = 256;

    // Reads always fetch the whole word; the formatter picks lanes on the load path.
    function automatic logic [3:0] bus_be_sel(input logic is_write, input logic [3:0] strobes);
        return is_write ? strobes : 4'b1111;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter for aborting a stuck bus transaction; 1-cycle registered count,
// expired is combinational from the count. No backpressure: clear wins over enable.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/data_bus_master.sv
// Memory-stage bus master: one req/gnt/rvalid transaction per access, min 4 cycles (IDLE,REQ,WAIT,RESP).
// Stalls the pipeline until RESP; waits on gnt/rvalid indefinitely unless BUS_TIMEOUT_EN enables the abort counter.
module data_bus_master
    import dbm_defs_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DBM_TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           data_to_mem_i,
    input  logic [3:0]            byte_select_i,
    output logic [31:0]           data_from_mem_o,
    output logic                  stall_o,
    output logic                  err_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [31:0]           bus_wdata_o,
    output logic [3:0]            bus_be_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [31:0]           bus_rdata_i,
    input  logic                  bus_err_i
);

    dbm_state_t state, state_nxt;

    logic req;
    logic latch_en;
    logic capture_en;
    logic timeout_hit;
    logic abort;
    logic unused_addr_lsb;

    assign req        = mem_read_i | mem_write_i;
    assign latch_en   = (state == ST_IDLE) && req;
    assign capture_en = (state == ST_WAIT) && bus_rvalid_i;
    // A response arriving on the last allowed cycle still completes normally.
    assign abort      = ((state == ST_REQ) || (state == ST_WAIT)) && timeout_hit && !capture_en;

    assign unused_addr_lsb = ^addr_i[1:0];

`ifdef BUS_TIMEOUT_EN
    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (latch_en),
        .enable  ((state == ST_REQ) || (state == ST_WAIT)),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign timeout_hit          = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (req) state_nxt = ST_REQ;
            ST_REQ: begin
                if (abort)          state_nxt = ST_RESP;
                else if (bus_gnt_i) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture_en || abort) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req_o = (state == ST_REQ);
        stall_o   = req && (state != ST_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_we_o        <= 1'b0;
            bus_addr_o      <= '0;
            bus_wdata_o     <= '0;
            bus_be_o        <= 4'b0000;
            data_from_mem_o <= '0;
            err_o           <= 1'b0;
        end else begin
            if (latch_en) begin
                bus_we_o    <= mem_write_i;
                bus_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                bus_wdata_o <= data_to_mem_i;
                bus_be_o    <= bus_be_sel(mem_write_i, byte_select_i);
            end

            if (capture_en && !bus_we_o) begin
                data_from_mem_o <= bus_rdata_i;
            end else if (abort) begin
                data_from_mem_o <= '0;
            end

            if (capture_en) begin
                err_o <= bus_err_i;
            end else if (abort) begin
                err_o <= 1'b1;
            end else if (state == ST_RESP) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master: loads, stores, slow grant, bus error,
// async reset mid-transaction, flush, back-to-back and (with BUS_TIMEOUT_EN) abort.
module tb_data_bus_master;
    import dbm_defs_pkg::*;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata_in;
    logic [3:0]    bsel;
    logic [31:0]   dout;
    logic          stall, err;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_be;
    logic          gnt, rvalid, berr;
    logic [31:0]   rdata;

    int checks = 0;
    int errors = 0;
    int handshakes = 0;
    int hs_before;

    always #5 clk = ~clk;

    data_bus_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .mem_read_i      (mem_read),
        .mem_write_i     (mem_write),
        .addr_i          (addr),
        .data_to_mem_i   (wdata_in),
        .byte_select_i   (bsel),
        .data_from_mem_o (dout),
        .stall_o         (stall),
        .err_o           (err),
        .bus_req_o       (bus_req),
        .bus_we_o        (bus_we),
        .bus_addr_o      (bus_addr),
        .bus_wdata_o     (bus_wdata),
        .bus_be_o        (bus_be),
        .bus_gnt_i       (gnt),
        .bus_rvalid_i    (rvalid),
        .bus_rdata_i     (rdata),
        .bus_err_i       (berr)
    );

    always @(posedge clk) if (bus_req && gnt) handshakes <= handshakes + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 0; mem_write = 0; addr = '0; wdata_in = '0; bsel = '0;
        gnt = 0; rvalid = 0; berr = 0; rdata = '0;
        #23;
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        tick();

        // lw 0x1004: gnt in cycle 2, rvalid in cycle 3
        mem_read = 1; addr = 32'h1004; settle();
        chk("lw_c1_stall", {31'd0, stall}, 32'd1);
        chk("lw_c1_req", {31'd0, bus_req}, 32'd0);
        tick(); gnt = 1; settle();
        chk("lw_c2_req", {31'd0, bus_req}, 32'd1);
        chk("lw_addr", bus_addr, 32'h1004);
        chk("lw_be", {28'd0, bus_be}, 32'hF);
        chk("lw_we", {31'd0, bus_we}, 32'd0);
        chk("lw_c2_stall", {31'd0, stall}, 32'd1);
        tick(); gnt = 0; rvalid = 1; rdata = 32'hCAFEBABE; settle();
        chk("lw_c3_req", {31'd0, bus_req}, 32'd0);
        chk("lw_c3_stall", {31'd0, stall}, 32'd1);
        tick(); rvalid = 0; rdata = '0; settle();
        chk("lw_resp_stall", {31'd0, stall}, 32'd0);
        chk("lw_dout", dout, 32'hCAFEBABE);
        chk("lw_err", {31'd0, err}, 32'd0);
        mem_read = 0;
        tick();

        // sb 0x2003, lane 3
        mem_write = 1; addr = 32'h2003; bsel = 4'b1000; wdata_in = 32'h5A5A5A5A;
        tick(); gnt = 1; settle();
        chk("sb_addr", bus_addr, 32'h2000);
        chk("sb_be", {28'd0, bus_be}, 32'h8);
        chk("sb_we", {31'd0, bus_we}, 32'd1);
        chk("sb_wdata", bus_wdata, 32'h5A5A5A5A);
        tick(); gnt = 0; rvalid = 1; rdata = 32'hDEADBEEF;
        tick(); rvalid = 0; settle();
        chk("sb_resp_stall", {31'd0, stall}, 32'd0);
        chk("sb_dout_hold", dout, 32'hCAFEBABE);
        mem_write = 0; bsel = '0;
        tick();

        // gnt withheld 5 cycles, stray rvalid in REQ ignored
        hs_before = handshakes;
        mem_read = 1; addr = 32'h3009;
        tick();
        for (int i = 0; i < 6; i++) begin
            gnt = (i == 5); rvalid = (i == 0); rdata = 32'hBAD0BAD0; settle();
            chk("slow_req", {31'd0, bus_req}, 32'd1);
            chk("slow_addr", bus_addr, 32'h3008);
            chk("slow_be", {28'd0, bus_be}, 32'hF);
            chk("slow_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        gnt = 0; rvalid = 0; settle();
        chk("slow_wait1_stall", {31'd0, stall}, 32'd1);
        chk("slow_wait1_req", {31'd0, bus_req}, 32'd0);
        chk("slow_dout_ignored", dout, 32'hCAFEBABE);
        tick(); rvalid = 1; rdata = 32'h12345678;
        tick(); rvalid = 0; settle();
        chk("slow_dout", dout, 32'h12345678);
        chk("slow_resp_stall", {31'd0, stall}, 32'd0);
        chk("slow_handshakes", handshakes - hs_before, 32'd1);

        // back-to-back load that returns a bus error
        tick(); addr = 32'h400C; settle();
        chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
        tick(); gnt = 1; settle();
        chk("b2b_addr", bus_addr, 32'h400C);
        tick(); gnt = 0; rvalid = 1; berr = 1; rdata = 32'h0BADF00D;
        tick(); rvalid = 0; berr = 0; settle();
        chk("err_resp", {31'd0, err}, 32'd1);
        chk("err_resp_stall", {31'd0, stall}, 32'd0);
        chk("err_dout", dout, 32'h0BADF00D);
        mem_read = 0;
        tick();
        chk("err_clear", {31'd0, err}, 32'd0);

        // async reset while in WAIT
        mem_read = 1; addr = 32'h5000;
        tick(); gnt = 1;
        tick(); gnt = 0; settle();
        chk("rst_pre_state", {30'd0, dut.state}, {30'd0, ST_WAIT});
        #2 rst_n = 0; #1;
        chk("rst_mid_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_dout", dout, 32'd0);
        mem_read = 0;
        tick(); rst_n = 1; rvalid = 1; rdata = 32'hFFFF0000;
        tick(); rvalid = 0; settle();
        chk("stray_state", {30'd0, dut.state}, {30'd0, ST_IDLE});
        chk("stray_dout", dout, 32'd0);
        mem_read = 1; addr = 32'h6004;
        tick(); gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata = 32'h11223344;
        tick(); rvalid = 0; settle();
        chk("post_rst_dout", dout, 32'h11223344);
        mem_read = 0;
        tick();

        // flush: req dropped in REQ, transaction still runs to RESP
        mem_read = 1; addr = 32'h7000;
        tick(); mem_read = 0; settle();
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_req", {31'd0, bus_req}, 32'd1);
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata = 32'h0F0F0F0F;
        tick(); rvalid = 0; settle();
        chk("flush_resp_state", {30'd0, dut.state}, {30'd0, ST_RESP});
        tick();
        chk("flush_idle_state", {30'd0, dut.state}, {30'd0, ST_IDLE});

        // no grant ever: abort with timeout, otherwise keep requesting
        mem_read = 1; addr = 32'h8000;
        tick();
        for (int i = 0; i < TO; i++) begin
            settle();
            chk("nognt_req", {31'd0, bus_req}, 32'd1);
            tick();
        end
`ifdef BUS_TIMEOUT_EN
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_dout", dout, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        chk("to_req", {31'd0, bus_req}, 32'd0);
        mem_read = 0;
        tick(); rvalid = 1;
        tick(); rvalid = 0; settle();
        chk("to_late_rvalid", {30'd0, dut.state}, {30'd0, ST_IDLE});
`else
        chk("nogo_req", {31'd0, bus_req}, 32'd1);
        chk("nogo_stall", {31'd0, stall}, 32'd1);
        chk("nogo_err", {31'd0, err}, 32'd0);
        gnt = 1;
        tick(); gnt = 0; rvalid = 1; rdata = 32'hA5A5A5A5;
        tick(); rvalid = 0; settle();
        chk("nogo_dout", dout, 32'hA5A5A5A5);
        mem_read = 0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
